exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the in-order five-stage CPU, sitting between ID and MEM. It latches the decoded instruction from ID under a valid/allowin handshake and evaluates a 12-operation ALU. It issues the data-SRAM request for loads and stores, then transmits the packed 71-bit result bus that the MEM stage receives. It also exports its destination register and result to ID for hazard detection and forwarding.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ds_to_es_valid  in  1  ID holds a valid instruction.
- ds_to_es_bus  in  148  packed as {alu_op[147:136], alu_src1[135:104], alu_src2[103:72], rkd_value[71:40], mem_we[39], res_from_mem[38], gr_we[37], dest[36:32], pc[31:0]}.
- es_allowin  out  1  EXE can accept an instruction this cycle.
- ms_allowin  in  1  MEM can accept an instruction this cycle.
- es_to_ms_valid  out  1  EXE presents a valid instruction to MEM.
- es_to_ms_bus  out  71  packed as {pc[70:39], gr_we[38], dest[37:33], alu_result[32:1], res_from_mem[0]}.
- data_sram_en  out  1  data SRAM access enable.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  byte address (= alu_result).
- data_sram_wdata  out  32  store data (= latched rkd_value).
- es_to_ds_dest  out  5  dest gated by es_valid && gr_we; 0 otherwise.
- es_forward_data  out  32  alu_result, for ID bypass.

## Operation
- Internal state: es_valid plus payload registers (alu_op, src1, src2, rkd_value, mem_we, res_from_mem, gr_we, dest, pc).
- es_ready_go = 1 (single-cycle ALU).
- es_allowin = !es_valid || (es_ready_go && ms_allowin).
- es_to_ms_valid = es_valid && es_ready_go.
- On each edge with es_allowin=1: es_valid <= ds_to_es_valid.
- Payload registers load only when ds_to_es_valid && es_allowin. Otherwise they hold.
- ALU (combinational on latched payload). alu_op is one-hot: bit0 add, 1 sub, 2 slt (signed), 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui (result = src2).
- Add/sub wrap modulo 2^32; no overflow trap.
- Shifts use src2[4:0] as the shift amount and src1 as the operand.
- slt/sltu produce 32'h0/32'h1.
- alu_op = 0 gives result 0. Multiple bits set gives the OR of the selected results; ID never generates this.
- Memory request: data_sram_en = es_valid && ms_allowin && (mem_we || res_from_mem).
- data_sram_we = {4{es_valid && ms_allowin && mem_we}}. Word accesses only.
- Gating on ms_allowin means a stalled MEM never sees a duplicate load or a repeated store.
- es_to_ds_dest = dest when es_valid && gr_we, else 5'd0.

## Timing
- Reset (asynchronous, immediate) clears es_valid and all payload registers.
- Output values while reset is asserted:
  - es_to_ms_valid=0, es_allowin=1, data_sram_en=0, data_sram_we=0.
  - es_to_ds_dest=0.
  - es_to_ms_bus=0, data_sram_addr=0, data_sram_wdata=0, es_forward_data=0 (payload cleared; alu_op=0 gives result 0).
- Latency: an instruction accepted at edge N is presented to MEM during cycle N..N+1, and its SRAM request is issued in that same cycle. The transfer completes at edge N+1 if ms_allowin=1.
- ms_allowin=0 with es_valid=1:
  - es_allowin=0; payload and outputs held stable.
  - data_sram_en=0 and data_sram_we=0.
- Simultaneous EXE→MEM transfer and ID→EXE load in the same edge is full throughput (back-to-back, no bubble).
- ds_to_es_valid=0 while es_allowin=1: es_valid drops and the payload is held. es_to_ds_dest then reads 0.
- Reset asserted mid-stall drops the in-flight instruction; no SRAM enable in the reset cycle.

## Test plan
- Reset then add: src1=32'h7FFF_FFFF, src2=1, alu_op bit0, gr_we=1, dest=5 -> next cycle es_to_ms_valid=1, alu_result=32'h8000_0000, es_to_ds_dest=5, data_sram_en=0.
- Shift and compare: sra src1=32'h8000_0000, src2=4 -> 32'hF800_0000; slt src1=-1, src2=1 -> 1; sltu with the same operands -> 0.
- Load: res_from_mem=1, src1=32'h1000, src2=8 -> data_sram_en=1, we=4'h0, addr=32'h1008, bus[0]=1.
- Store under MEM stall: mem_we=1, rkd_value=32'hDEAD_BEEF, ms_allowin=0 for 3 cycles then 1:
  - during stall: data_sram_en=0, es_allowin=0, bus held.
  - release cycle: we=4'hF and wdata=32'hDEAD_BEEF for exactly one cycle.
- Back-to-back stream of 4 instructions with ms_allowin=1 -> 4 consecutive es_to_ms_valid cycles with the correct pc sequence; a single ds_to_es_valid=0 bubble yields exactly one invalid cycle.
- Reset asserted during a held load -> es_to_ms_valid and data_sram_en fall immediately (same cycle, before the next edge); after release, es_allowin=1 and the bus reads 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of the five-stage in-order CPU: latches the decoded instruction
// from ID, evaluates the ALU, issues the data-SRAM request and drives the MEM bus.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ds_to_es_valid,
    input  logic [147:0] ds_to_es_bus,
    output logic         es_allowin,
    input  logic         ms_allowin,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [4:0]   es_to_ds_dest,
    output logic [31:0]  es_forward_data
);

    logic         es_valid;
    logic         es_ready_go;
    logic [11:0]  es_alu_op;
    logic [31:0]  es_src1;
    logic [31:0]  es_src2;
    logic [31:0]  es_rkd_value;
    logic         es_mem_we;
    logic         es_res_from_mem;
    logic         es_gr_we;
    logic [4:0]   es_dest;
    logic [31:0]  es_pc;
    logic [31:0]  alu_result;

    // One-hot opcode; several bits set yield the OR of the selected results.
    function automatic logic [31:0] alu_eval(input logic [11:0] op,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
        logic [31:0] r;
        logic [4:0]  sa;
        sa = b[4:0];
        r  = '0;
        if (op[0])  r = r | 32'(a + b);
        if (op[1])  r = r | 32'(a - b);
        if (op[2])  r = r | {31'd0, (a < b)};
        if (op[3])  r = r | {31'd0, ($unsigned(a) < $unsigned(b))};
        if (op[4])  r = r | (a & b);
        if (op[5])  r = r | ~(a | b);
        if (op[6])  r = r | (a | b);
        if (op[7])  r = r | (a ^ b);
        if (op[8])  r = r | ($unsigned(a) << sa);
        if (op[9])  r = r | ($unsigned(a) >> sa);
        if (op[10]) r = r | 32'(a >>> sa);
        if (op[11]) r = r | b;
        return r;
    endfunction

    assign es_ready_go    = 1'b1;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    // ID -> EXE boundary: payload loads only on an accepted valid instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid        <= 1'b0;
            es_alu_op       <= '0;
            es_src1         <= '0;
            es_src2         <= '0;
            es_rkd_value    <= '0;
            es_mem_we       <= 1'b0;
            es_res_from_mem <= 1'b0;
            es_gr_we        <= 1'b0;
            es_dest         <= '0;
            es_pc           <= '0;
        end else begin
            if (es_allowin) begin
                es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin) begin
                {es_alu_op, es_src1, es_src2, es_rkd_value, es_mem_we,
                 es_res_from_mem, es_gr_we, es_dest, es_pc} <= ds_to_es_bus;
            end
        end
    end

    assign alu_result = alu_eval(es_alu_op, $signed(es_src1), $signed(es_src2));

    // EXE -> MEM boundary: requests are gated by ms_allowin so a stall never repeats them.
    assign es_to_ms_bus    = {es_pc, es_gr_we, es_dest, alu_result, es_res_from_mem};
    assign data_sram_en    = es_valid && ms_allowin && (es_mem_we || es_res_from_mem);
    assign data_sram_we    = {4{es_valid && ms_allowin && es_mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_rkd_value;
    assign es_to_ds_dest   = (es_valid && es_gr_we) ? es_dest : 5'd0;
    assign es_forward_data = alu_result;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: table of ALU vectors streamed through a scoreboard,
// plus hand sequences for reset, load, stalled store, bubble and reset-in-stall.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ds_to_es_valid;
    logic [147:0] ds_to_es_bus;
    logic         es_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   es_to_ds_dest;
    logic [31:0]  es_forward_data;

    exe_stage dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_allowin(es_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .es_to_ds_dest(es_to_ds_dest), .es_forward_data(es_forward_data)
    );

    typedef struct {
        logic [70:0] bus;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  dsd;
    } exp_t;

    typedef struct {
        logic [11:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];
    vec_t vt[14];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [147:0] mk(input logic [11:0] op, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] rkd,
                                        input logic mwe, input logic rfm, input logic gwe,
                                        input logic [4:0] d, input logic [31:0] pc);
        return {op, s1, s2, rkd, mwe, rfm, gwe, d, pc};
    endfunction

    function automatic exp_t mkexp(input logic [31:0] res, input logic [31:0] rkd,
                                   input logic mwe, input logic rfm, input logic gwe,
                                   input logic [4:0] d, input logic [31:0] pc);
        exp_t e;
        e.bus   = {pc, gwe, d, res, rfm};
        e.en    = mwe | rfm;
        e.we    = {4{mwe}};
        e.addr  = res;
        e.wdata = rkd;
        e.dsd   = gwe ? d : 5'd0;
        return e;
    endfunction

    task automatic send(input logic v, input logic [147:0] b, input exp_t e);
        ds_to_es_valid = v;
        ds_to_es_bus   = b;
        if (v) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every EXE->MEM transfer is compared against the oldest pushed record.
    always @(negedge clk) begin
        if (!reset && es_to_ms_valid && ms_allowin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no transfer", es_to_ms_bus[70:39]);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_bus",   es_to_ms_bus, e.bus);
                chk("sb_en",    71'(data_sram_en), 71'(e.en));
                chk("sb_we",    71'(data_sram_we), 71'(e.we));
                chk("sb_addr",  71'(data_sram_addr), 71'(e.addr));
                chk("sb_wdata", 71'(data_sram_wdata), 71'(e.wdata));
                chk("sb_dsd",   71'(es_to_ds_dest), 71'(e.dsd));
                chk("sb_fwd",   71'(es_forward_data), 71'(e.addr));
            end
        end
    end

    exp_t none;
    exp_t e_ld;
    exp_t e_st;

    initial begin
        vt[0]  = '{12'h001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000}; // add wraps
        vt[1]  = '{12'h002, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF}; // sub
        vt[2]  = '{12'h004, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001}; // slt -1<1
        vt[3]  = '{12'h008, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000}; // sltu
        vt[4]  = '{12'h010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000}; // and
        vt[5]  = '{12'h020, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F}; // nor
        vt[6]  = '{12'h040, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678}; // or
        vt[7]  = '{12'h080, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F}; // xor
        vt[8]  = '{12'h100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000}; // sll 31
        vt[9]  = '{12'h200, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000}; // srl
        vt[10] = '{12'h400, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000}; // sra
        vt[11] = '{12'h800, 32'h1234_5000, 32'hABCD_E000, 32'hABCD_E000}; // lui
        vt[12] = '{12'h100, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010}; // sll uses [4:0]
        vt[13] = '{12'h000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000}; // no op

        none           = mkexp('0, '0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h001, 32'h5, 32'h6, 32'h7, 1'b1, 1'b0, 1'b1, 5'd3, 32'h40);
        @(posedge clk);
        #1;
        chk("rst_valid",   71'(es_to_ms_valid), 71'(0));
        chk("rst_allowin", 71'(es_allowin), 71'(1));
        chk("rst_en",      71'(data_sram_en), 71'(0));
        chk("rst_we",      71'(data_sram_we), 71'(0));
        chk("rst_dsd",     71'(es_to_ds_dest), 71'(0));
        chk("rst_bus",     es_to_ms_bus, 71'(0));
        chk("rst_addr",    71'(data_sram_addr), 71'(0));
        chk("rst_wdata",   71'(data_sram_wdata), 71'(0));
        chk("rst_fwd",     71'(es_forward_data), 71'(0));
        ds_to_es_valid = 1'b0;
        reset          = 1'b0;

        // Back-to-back table stream through the scoreboard.
        for (int i = 0; i < 14; i++) begin
            logic [31:0] pc;
            logic [31:0] rkd;
            pc  = 32'h1000 + 32'(i * 4);
            rkd = 32'hA000 + 32'(i);
            send(1'b1, mk(vt[i].op, vt[i].a, vt[i].b, rkd, 1'b0, 1'b0, 1'b1, 5'(i + 5), pc),
                 mkexp(vt[i].r, rkd, 1'b0, 1'b0, 1'b1, 5'(i + 5), pc));
            chk("stream_valid", 71'(es_to_ms_valid), 71'(1));
            if (i == 0) begin
                chk("add_result", 71'(es_to_ms_bus[32:1]), 71'(32'h8000_0000));
                chk("add_dsd",    71'(es_to_ds_dest), 71'(5));
                chk("add_en",     71'(data_sram_en), 71'(0));
            end
        end
        send(1'b0, '0, none);
        chk("drain_valid", 71'(es_to_ms_valid), 71'(0));
        chk("drain_dsd",   71'(es_to_ds_dest), 71'(0));

        // Load request.
        e_ld = mkexp(32'h1008, 32'h55, 1'b0, 1'b1, 1'b1, 5'd9, 32'h2000);
        send(1'b1, mk(12'h001, 32'h1000, 32'h8, 32'h55, 1'b0, 1'b1, 1'b1, 5'd9, 32'h2000), e_ld);
        chk("ld_en",   71'(data_sram_en), 71'(1));
        chk("ld_we",   71'(data_sram_we), 71'(0));
        chk("ld_addr", 71'(data_sram_addr), 71'(32'h1008));
        chk("ld_bus0", 71'(es_to_ms_bus[0]), 71'(1));
        send(1'b0, '0, none);

        // Store held by a three-cycle MEM stall.
        ms_allowin = 1'b0;
        e_st = mkexp(32'h2004, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h2004);
        send(1'b1, mk(12'h001, 32'h2000, 32'h4, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h2004), e_st);
        for (int k = 0; k < 3; k++) begin
            chk("st_stall_valid",   71'(es_to_ms_valid), 71'(1));
            chk("st_stall_en",      71'(data_sram_en), 71'(0));
            chk("st_stall_we",      71'(data_sram_we), 71'(0));
            chk("st_stall_allowin", 71'(es_allowin), 71'(0));
            chk("st_stall_bus",     es_to_ms_bus, e_st.bus);
            if (k < 2) send(1'b0, '0, none);
        end
        ds_to_es_valid = 1'b0;
        ms_allowin     = 1'b1;
        #1;
        chk("st_rel_we",    71'(data_sram_we), 71'(4'hF));
        chk("st_rel_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
        @(posedge clk);
        #1;
        chk("st_after_we",    71'(data_sram_we), 71'(0));
        chk("st_after_valid", 71'(es_to_ms_valid), 71'(0));

        // Stream with a single bubble: valid pattern 1,1,0,1,1.
        for (int s = 0; s < 5; s++) begin
            logic [31:0] pc;
            pc = 32'h3000 + 32'(s * 4);
            if (s == 2) begin
                send(1'b0, '0, none);
                chk("bub_valid", 71'(es_to_ms_valid), 71'(0));
                chk("bub_dsd",   71'(es_to_ds_dest), 71'(0));
            end else begin
                send(1'b1, mk(12'h040, pc, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, pc),
                     mkexp(pc | 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, pc));
                chk("bub_stream_valid", 71'(es_to_ms_valid), 71'(1));
            end
        end
        send(1'b0, '0, none);

        // Reset asserted while a load is held by MEM.
        ms_allowin = 1'b0;
        send(1'b1, mk(12'h001, 32'h4000, 32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h5000),
             mkexp(32'h4004, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h5000));
        send(1'b0, '0, none);
        chk("hold_valid", 71'(es_to_ms_valid), 71'(1));
        reset      = 1'b1;
        ms_allowin = 1'b1;
        #1;
        chk("rst_mid_valid",   71'(es_to_ms_valid), 71'(0));
        chk("rst_mid_en",      71'(data_sram_en), 71'(0));
        chk("rst_mid_allowin", 71'(es_allowin), 71'(1));
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_allowin", 71'(es_allowin), 71'(1));
        chk("post_rst_bus",     es_to_ms_bus, 71'(0));
        chk("post_rst_valid",   71'(es_to_ms_valid), 71'(0));

        chk("sb_drained", 71'(sb.size()), 71'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
